// File: rtl/alu_result_checker.sv
// alu_result_checker: golden-model monitor for the 16-bit ALU result port
// Ports:
//   i_c          clock, rising edge
//   i_r          asynchronous active-low reset
//   i_en         checking enable (IDLE->RUN), level
//   i_clr        synchronous clear of counters/capture, FSM back to IDLE
//   i_vld        command issued to the ALU this cycle
//   i_s/i_x/i_y  issued select and operands
//   i_z          ALU result, valid LAT cycles after issue
//   o_pass_cnt   matched results (saturating)
//   o_fail_cnt   mismatched results (saturating)
//   o_skip_cnt   masked divide-by-zero checks (saturating)
//   o_err        sticky mismatch flag
//   o_err_op/o_err_exp/o_err_got  capture of the first mismatch
//   o_busy       some pipeline stage holds a valid entry
module alu_result_checker #(
    parameter int LAT         = 1,
    parameter bit STOP_ON_ERR = 1'b1
) (
    input  logic        i_c,
    input  logic        i_r,
    input  logic        i_en,
    input  logic        i_clr,
    input  logic        i_vld,
    input  logic [3:0]  i_s,
    input  logic [15:0] i_x,
    input  logic [15:0] i_y,
    input  logic [31:0] i_z,
    output logic [15:0] o_pass_cnt,
    output logic [15:0] o_fail_cnt,
    output logic [7:0]  o_skip_cnt,
    output logic        o_err,
    output logic [3:0]  o_err_op,
    output logic [31:0] o_err_exp,
    output logic [31:0] o_err_got,
    output logic        o_busy
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;
    state_t      r_state, w_state_nxt;
    logic        r_vld  [LAT];
    logic [3:0]  r_op   [LAT];
    logic [31:0] r_exp  [LAT];
    logic        r_mask [LAT];
    logic        r_res_vld, r_res_skip, r_res_pass;
    logic [3:0]  r_res_op;
    logic [31:0] r_res_exp, r_res_got;
    logic [15:0] r_pass_cnt, r_fail_cnt;
    logic [7:0]  r_skip_cnt;
    logic        r_err;
    logic [3:0]  r_err_op;
    logic [31:0] r_err_exp, r_err_got;
    logic [31:0] w_x, w_y, w_gold;
    logic        w_mask, w_busy, w_stop, w_acc, w_cmp;

    assign w_x = {16'h0, i_x};
    assign w_y = {16'h0, i_y};

    always_comb begin
        w_gold = '0;
        case (i_s)
            4'h0:    w_gold = w_x + w_y;
            4'h1:    w_gold = w_x - w_y;
            4'h2:    w_gold = w_x * w_y;
            4'h3:    w_gold = (i_y == 16'h0) ? 32'h0 : w_x / w_y;
            4'h4:    w_gold = {16'h0, i_x[14:0], 1'b0};
            4'h5:    w_gold = {17'h0, i_x[15:1]};
            4'h6:    w_gold = {16'h0, i_x[14:0], i_x[15]};
            4'h7:    w_gold = {16'h0, i_x[0], i_x[15:1]};
            4'h8:    w_gold = {16'h0, i_x & i_y};
            4'h9:    w_gold = {16'h0, i_x | i_y};
            4'ha:    w_gold = {16'h0, ~(i_x | i_y)};
            4'hb:    w_gold = {16'h0, ~(i_x & i_y)};
            4'hc:    w_gold = {16'h0, i_x ^ i_y};
            4'hd:    w_gold = {16'h0, ~(i_x ^ i_y)};
            4'he:    w_gold = {31'h0, i_x < i_y};
            default: w_gold = {31'h0, i_x == i_y};
        endcase
    end

    assign w_mask = (i_s == 4'h3) && (i_y == 16'h0);

    always_comb begin
        w_busy = 1'b0;
        for (int i = 0; i < LAT; i++) w_busy = w_busy | r_vld[i];
    end

    // A registered mismatch stops everything in the same edge: the pipe is
    // flushed and neither a new issue nor a pending compare is taken.
    assign w_stop = STOP_ON_ERR && (r_state == S_RUN) && r_res_vld && !r_res_skip && !r_res_pass;
    assign w_acc  = i_vld && (r_state == S_RUN) && !w_stop;
    assign w_cmp  = r_vld[LAT-1] && !w_stop;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = i_en ? S_RUN : S_IDLE;
            S_RUN:   w_state_nxt = w_stop ? S_HALT : (!i_en && !w_busy) ? S_IDLE : S_RUN;
            S_HALT:  w_state_nxt = S_HALT;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_c or negedge i_r) begin
        if (!i_r)
            r_state <= S_IDLE;
        else if (i_clr)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge i_c or negedge i_r) begin
        if (!i_r) begin
            for (int i = 0; i < LAT; i++) begin
                r_vld[i]  <= 1'b0;
                r_op[i]   <= '0;
                r_exp[i]  <= '0;
                r_mask[i] <= 1'b0;
            end
        end else if (i_clr || w_stop) begin
            for (int i = 0; i < LAT; i++) r_vld[i] <= 1'b0;
        end else begin
            r_vld[0]  <= w_acc;
            r_op[0]   <= i_s;
            r_exp[0]  <= w_gold;
            r_mask[0] <= w_mask;
            for (int i = 1; i < LAT; i++) begin
                r_vld[i]  <= r_vld[i-1];
                r_op[i]   <= r_op[i-1];
                r_exp[i]  <= r_exp[i-1];
                r_mask[i] <= r_mask[i-1];
            end
        end
    end

    // Compare outcome is registered; counters consume it one edge later.
    always_ff @(posedge i_c or negedge i_r) begin
        if (!i_r) begin
            r_res_vld  <= 1'b0;
            r_res_skip <= 1'b0;
            r_res_pass <= 1'b0;
            r_res_op   <= '0;
            r_res_exp  <= '0;
            r_res_got  <= '0;
        end else if (i_clr) begin
            r_res_vld  <= 1'b0;
        end else begin
            r_res_vld  <= w_cmp;
            r_res_skip <= r_mask[LAT-1];
            r_res_pass <= (r_exp[LAT-1] == i_z);
            r_res_op   <= r_op[LAT-1];
            r_res_exp  <= r_exp[LAT-1];
            r_res_got  <= i_z;
        end
    end

    always_ff @(posedge i_c or negedge i_r) begin
        if (!i_r || i_clr) begin
            r_pass_cnt <= '0;
            r_fail_cnt <= '0;
            r_skip_cnt <= '0;
            r_err      <= 1'b0;
            r_err_op   <= '0;
            r_err_exp  <= '0;
            r_err_got  <= '0;
        end else if (r_res_vld) begin
            if (r_res_skip)
                r_skip_cnt <= (r_skip_cnt == 8'hFF) ? r_skip_cnt : r_skip_cnt + 8'h1;
            else if (r_res_pass)
                r_pass_cnt <= (r_pass_cnt == 16'hFFFF) ? r_pass_cnt : r_pass_cnt + 16'h1;
            else begin
                r_fail_cnt <= (r_fail_cnt == 16'hFFFF) ? r_fail_cnt : r_fail_cnt + 16'h1;
                r_err      <= 1'b1;
                if (!r_err) begin
                    r_err_op  <= r_res_op;
                    r_err_exp <= r_res_exp;
                    r_err_got <= r_res_got;
                end
            end
        end
    end

    assign o_pass_cnt = r_pass_cnt;
    assign o_fail_cnt = r_fail_cnt;
    assign o_skip_cnt = r_skip_cnt;
    assign o_err      = r_err;
    assign o_err_op   = r_err_op;
    assign o_err_exp  = r_err_exp;
    assign o_err_got  = r_err_got;
    assign o_busy     = w_busy;
endmodule

// File: tb/tb_alu_result_checker.sv
// tb_alu_result_checker: scoreboard bench driving a LAT=1 stop-on-error and a LAT=3 keep-counting checker
module tb_alu_result_checker;
    typedef struct packed {
        logic [1:0]  cat;
        logic [3:0]  op;
        logic [31:0] exp;
        logic [31:0] got;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n, en, clr, vld;
    logic [3:0]  s;
    logic [15:0] x, y;
    logic [31:0] flt;
    logic [31:0] zp [3];
    logic [15:0] pc [2];
    logic [15:0] fc [2];
    logic [7:0]  sc [2];
    logic        er [2];
    logic [3:0]  eo [2];
    logic [31:0] ee [2];
    logic [31:0] eg [2];
    logic        bz [2];

    int   nchk = 0, nerr = 0;
    ent_t q0[$], q1[$];
    bit   run [2];
    bit   m_err [2];
    int   m_p [2], m_f [2], m_k [2];
    bit   mon_off;
    logic [15:0] pv_p [2], pv_f [2];
    logic [7:0]  pv_k [2];
    int   dp, df, dk, ev, gcat;
    ent_t me;

    always #5 clk = ~clk;

    alu_result_checker #(.LAT(1), .STOP_ON_ERR(1'b1)) dut_a (
        .i_c(clk), .i_r(rst_n), .i_en(en), .i_clr(clr), .i_vld(vld),
        .i_s(s), .i_x(x), .i_y(y), .i_z(zp[0]),
        .o_pass_cnt(pc[0]), .o_fail_cnt(fc[0]), .o_skip_cnt(sc[0]), .o_err(er[0]),
        .o_err_op(eo[0]), .o_err_exp(ee[0]), .o_err_got(eg[0]), .o_busy(bz[0])
    );

    alu_result_checker #(.LAT(3), .STOP_ON_ERR(1'b0)) dut_b (
        .i_c(clk), .i_r(rst_n), .i_en(en), .i_clr(clr), .i_vld(vld),
        .i_s(s), .i_x(x), .i_y(y), .i_z(zp[2]),
        .o_pass_cnt(pc[1]), .o_fail_cnt(fc[1]), .o_skip_cnt(sc[1]), .o_err(er[1]),
        .o_err_op(eo[1]), .o_err_exp(ee[1]), .o_err_got(eg[1]), .o_busy(bz[1])
    );

    function automatic logic [31:0] golden(input logic [3:0] op, input logic [15:0] xi, input logic [15:0] yi);
        int unsigned a, b;
        logic [31:0] r;
        a = 32'(xi);
        b = 32'(yi);
        case (op)
            4'h0:    r = a + b;
            4'h1:    r = a - b;
            4'h2:    r = a * b;
            4'h3:    r = (b == 0) ? 0 : a / b;
            4'h4:    r = (a * 2) % 65536;
            4'h5:    r = a / 2;
            4'h6:    r = (a * 2) % 65536 + a / 32768;
            4'h7:    r = a / 2 + (a % 2) * 32768;
            4'h8:    r = a & b;
            4'h9:    r = a | b;
            4'ha:    r = (a | b) ^ 32'hFFFF;
            4'hb:    r = (a & b) ^ 32'hFFFF;
            4'hc:    r = a ^ b;
            4'hd:    r = (a ^ b) ^ 32'hFFFF;
            4'he:    r = (a < b) ? 1 : 0;
            default: r = (a == b) ? 1 : 0;
        endcase
        return r;
    endfunction

    // ALU behaviour: result of every issued command appears LAT cycles later.
    always @(posedge clk) begin
        zp[0] <= golden(s, x, y) ^ flt;
        zp[1] <= zp[0];
        zp[2] <= zp[1];
    end

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    task automatic qpush(input int d, input ent_t e);
        if (d == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic sb_reset();
        q0.delete();
        q1.delete();
        for (int d = 0; d < 2; d++) begin
            m_err[d] = 1'b0;
            m_p[d] = 0;
            m_f[d] = 0;
            m_k[d] = 0;
            run[d] = 1'b0;
        end
    endtask

    task automatic issue(input logic [3:0] si, input logic [15:0] xi, input logic [15:0] yi, input logic [31:0] fi);
        ent_t e;
        e.op  = si;
        e.exp = golden(si, xi, yi);
        e.got = e.exp ^ fi;
        e.cat = (si == 4'h3 && yi == 16'h0) ? 2'd2 : (fi != 0) ? 2'd1 : 2'd0;
        vld = 1'b1; s = si; x = xi; y = yi; flt = fi;
        for (int d = 0; d < 2; d++) begin
            if (run[d]) begin
                if (!mon_off) qpush(d, e);
                if (e.cat == 2'd0) m_p[d] = (m_p[d] < 65535) ? m_p[d] + 1 : m_p[d];
                else if (e.cat == 2'd1) m_f[d] = (m_f[d] < 65535) ? m_f[d] + 1 : m_f[d];
                else m_k[d] = (m_k[d] < 255) ? m_k[d] + 1 : m_k[d];
            end
        end
        tick();
        vld = 1'b0;
        flt = '0;
    endtask

    task automatic rand_issue();
        logic [3:0]  si;
        logic [15:0] xi, yi;
        si = 4'($urandom);
        xi = 16'($urandom);
        yi = ($urandom_range(7) == 0) ? 16'h0 : 16'($urandom);
        if (si >= 4'he && $urandom_range(1) == 1) yi = xi;
        issue(si, xi, yi, 32'h0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q0.size() + q1.size()) != 0 && n < 40) begin
            tick();
            n++;
        end
        chk("drain_pending", 128'(q0.size() + q1.size()), 128'(0));
    endtask

    task automatic chk_counts(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s_pass%0d", tag, d), 128'(pc[d]), 128'(m_p[d]));
            chk($sformatf("%s_fail%0d", tag, d), 128'(fc[d]), 128'(m_f[d]));
            chk($sformatf("%s_skip%0d", tag, d), 128'(sc[d]), 128'(m_k[d]));
            chk($sformatf("%s_err%0d", tag, d), 128'(er[d]), 128'(m_f[d] != 0));
        end
    endtask

    task automatic chk_zero(input string tag);
        for (int d = 0; d < 2; d++)
            chk($sformatf("%s_zero%0d", tag, d),
                128'({pc[d], fc[d], sc[d], er[d], eo[d], ee[d], eg[d], bz[d]}), 128'(0));
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; vld = 1'b0;
        s = '0; x = '0; y = '0; flt = '0;
        mon_off = 1'b1;
        sb_reset();

        fork
            forever begin
                @(posedge clk);
                #1;
                for (int d = 0; d < 2; d++) begin
                    if (!mon_off) begin
                        dp = int'(pc[d]) - int'(pv_p[d]);
                        df = int'(fc[d]) - int'(pv_f[d]);
                        dk = int'(sc[d]) - int'(pv_k[d]);
                        ev = dp + df + dk;
                        if (ev != 0) begin
                            chk($sformatf("step%0d", d), 128'(ev), 128'(1));
                            chk($sformatf("unexpected_check%0d", d), 128'(qsize(d) == 0), 128'(0));
                            if (ev == 1 && qsize(d) != 0) begin
                                me = (d == 0) ? q0.pop_front() : q1.pop_front();
                                gcat = (dp == 1) ? 0 : (df == 1) ? 1 : 2;
                                chk($sformatf("cat%0d_op%0h", d, me.op), 128'(gcat), 128'(me.cat));
                                if (me.cat == 2'd1 && !m_err[d]) begin
                                    chk($sformatf("capture%0d", d), 128'({eo[d], ee[d], eg[d]}),
                                        128'({me.op, me.exp, me.got}));
                                    m_err[d] = 1'b1;
                                end
                                chk($sformatf("sticky%0d", d), 128'(er[d]), 128'(m_err[d]));
                            end
                        end
                    end
                    pv_p[d] = pc[d];
                    pv_f[d] = fc[d];
                    pv_k[d] = sc[d];
                end
            end
        join_none

        repeat (3) tick();
        chk_zero("reset");
        rst_n = 1'b1;
        en = 1'b1;
        tick();
        run[0] = 1'b1; run[1] = 1'b1;
        mon_off = 1'b0;

        for (int i = 0; i < 16; i++) issue(4'(i), 16'h28, 16'h14, 32'h0);
        drain();
        chk_counts("sweep");

        issue(4'h3, 16'h28, 16'h0, 32'h0);
        drain();
        chk_counts("div0");

        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(3) == 0) tick();
            else rand_issue();
        end
        drain();
        chk_counts("random");

        issue(4'h0, 16'h28, 16'h14, 32'h1);
        run[0] = 1'b0;
        repeat (4) tick();
        issue(4'h2, 16'h28, 16'h14, 32'h100);
        repeat (4) tick();
        for (int i = 0; i < 6; i++) rand_issue();
        drain();
        chk("halt_fail", 128'(fc[0]), 128'(1));
        chk("halt_err", 128'(er[0]), 128'(1));
        chk("halt_op", 128'(eo[0]), 128'(0));
        chk("halt_exp", 128'(ee[0]), 128'(32'h3C));
        chk("halt_got", 128'(eg[0]), 128'(32'h3D));
        chk("halt_busy", 128'(bz[0]), 128'(0));
        chk("keep_fail", 128'(fc[1]), 128'(2));
        chk("keep_first_op", 128'(eo[1]), 128'(0));
        chk_counts("errors");

        mon_off = 1'b1;
        for (int i = 0; i < 260; i++) issue(4'h3, 16'($urandom), 16'h0, 32'h0);
        repeat (6) tick();
        chk("skip_sat", 128'(sc[1]), 128'(8'hFF));
        chk_counts("sat");

        clr = 1'b1;
        sb_reset();
        tick();
        clr = 1'b0;
        chk_zero("clr");
        tick();
        run[0] = 1'b1; run[1] = 1'b1;
        mon_off = 1'b0;

        for (int i = 0; i < 8; i++) rand_issue();
        en = 1'b0;
        chk("busy_a0", 128'(bz[0]), 128'(1));
        chk("busy_b0", 128'(bz[1]), 128'(1));
        tick();
        chk("busy_a1", 128'(bz[0]), 128'(0));
        chk("busy_b1", 128'(bz[1]), 128'(1));
        tick();
        chk("busy_b2", 128'(bz[1]), 128'(1));
        tick();
        chk("busy_b3", 128'(bz[1]), 128'(0));
        drain();
        run[0] = 1'b0; run[1] = 1'b0;
        for (int i = 0; i < 3; i++) rand_issue();
        repeat (6) tick();
        chk_counts("idle");

        en = 1'b1;
        tick();
        run[0] = 1'b1; run[1] = 1'b1;
        issue(4'h0, 16'h28, 16'h14, 32'h0);
        issue(4'h1, 16'h28, 16'h14, 32'h0);
        mon_off = 1'b1;
        sb_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("async_rst");
        tick();
        rst_n = 1'b1;
        tick();
        run[0] = 1'b1; run[1] = 1'b1;
        mon_off = 1'b0;
        repeat (8) tick();
        chk_counts("no_stale");
        chk("no_stale_busy", 128'({bz[0], bz[1]}), 128'(0));
        for (int i = 0; i < 10; i++) rand_issue();
        drain();
        chk_counts("final");

        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end
endmodule
